// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multicycle ARM-subset controller.
//   state_t    - FSM state encoding
//   cond_t     - ARM condition field codes
//   ALU_*      - ALUControl encodings
//   RES_*      - ResultSrc encodings
//   SRCB_*     - ALUSrcB encodings
//   OP_*       - instr[27:26] opcode classes
//   CMD_*      - data-processing Funct[4:1] command codes (CMP/MOV included)
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWRITE = 4'd4,
        MEMWB    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    function automatic logic cmd_legal(input logic [3:0] cmd);
        case (cmd)
            CMD_AND, CMD_SUB, CMD_ADD, CMD_ORR, CMD_CMP, CMD_MOV: cmd_legal = 1'b1;
            default:                                              cmd_legal = 1'b0;
        endcase
    endfunction

    // CMP is a SUB with no writeback; MOV uses the ORR path (Rn is zero).
    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD:          alu_decode = ALU_ADD;
            CMD_SUB, CMD_CMP: alu_decode = ALU_SUB;
            CMD_AND:          alu_decode = ALU_AND;
            CMD_ORR, CMD_MOV: alu_decode = ALU_ORR;
            default:          alu_decode = ALU_ADD;
        endcase
    endfunction

    // Commands whose carry/overflow outputs are meaningful.
    function automatic logic cmd_arith(input logic [3:0] cmd);
        cmd_arith = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
    endfunction

endpackage

// File: rtl/cond_unit.sv
// cond_unit: NZCV flags register plus ARM condition evaluation.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (flags clear to 0000)
//   cond        - instruction condition field
//   alu_flags   - NZCV from the ALU this cycle
//   we_nz       - load N and Z at the clock edge
//   we_cv       - load C and V at the clock edge
//   flags       - registered NZCV
//   cond_ok     - condition passes against the registered flags
module cond_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       we_nz,
    input  logic       we_cv,
    output logic [3:0] flags,
    output logic       cond_ok
);

    logic n, z, c, v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else begin
            if (we_nz) flags[3:2] <= alu_flags[3:2];
            if (we_cv) flags[1:0] <= alu_flags[1:0];
        end
    end

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ok = 1'b0;
        case (cond_t'(cond))
            COND_EQ: cond_ok = z;
            COND_NE: cond_ok = ~z;
            COND_CS: cond_ok = c;
            COND_CC: cond_ok = ~c;
            COND_MI: cond_ok = n;
            COND_PL: cond_ok = ~n;
            COND_VS: cond_ok = v;
            COND_VC: cond_ok = ~v;
            COND_HI: cond_ok = c & ~z;
            COND_LS: cond_ok = ~c | z;
            COND_GE: cond_ok = (n == v);
            COND_LT: cond_ok = (n != v);
            COND_GT: cond_ok = ~z & (n == v);
            COND_LE: cond_ok = z | (n != v);
            COND_AL: cond_ok = 1'b1;
            COND_NV: cond_ok = 1'b0;
            default: cond_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM control unit for the multicycle ARM-subset
// datapath (ADD/SUB/AND/ORR/CMP/MOV, LDR/STR, B) with one shared memory port.
// Optional feature macro: PERF_CNT_EN adds cycle_cnt / retired_cnt outputs.
//
// state    | meaning
// FETCH    | read instr at PC, PC <= PC+4 when memory ready
// DECODE   | read registers, evaluate condition, dispatch
// MEMADR   | compute Rn + imm address
// MEMREAD  | load access, waits on mem_ready
// MEMWRITE | store access, MemWrite held until mem_ready
// MEMWB    | write loaded data to Rd
// EXECUTER | ALU op with register operand, optional flag update
// EXECUTEI | ALU op with immediate operand, optional flag update
// ALUWB    | write ALU result to Rd (skipped for CMP)
// BRANCH   | PC <= PC+8+imm
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   instr          - instruction register (Cond, Op, Funct, Rd fields)
//   alu_flags      - NZCV from the ALU this cycle
//   mem_ready      - memory access completes this cycle
//   PCWrite, IRWrite, RegWrite, MemWrite - datapath enables
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl - mux/ALU selects
//   illegal_instr  - one-cycle pulse in DECODE on an unsupported encoding
//   cycle_cnt, retired_cnt - performance counters (PERF_CNT_EN only)
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = FETCH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [3:0]  alu_flags,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic        illegal_instr
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retired_cnt
`endif
);

    state_t state, next_state;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic [3:0] rd;
    logic       is_cmp;
    logic       rd_pc;
    logic       cond_ok;
    logic [3:0] flags;
    logic       we_nz, we_cv;
    logic       pcw_c, irw_c, regw_c, memw_c;
    logic       unused_instr_bits;

    assign cond   = instr[31:28];
    assign op     = instr[27:26];
    assign funct  = instr[25:20];
    assign cmd    = funct[4:1];
    assign rd     = instr[15:12];
    assign is_cmp = (cmd == CMD_CMP);
    assign rd_pc  = (rd == 4'd15);
    assign unused_instr_bits = ^{instr[19:16], instr[11:0], flags};

    assign ImmSrc = op;
    assign RegSrc = {(op == OP_MEM) & ~funct[0], (op == OP_BR)};

    cond_unit u_cond (
        .clk       (clk),
        .rst_n     (rst_n),
        .cond      (cond),
        .alu_flags (alu_flags),
        .we_nz     (we_nz),
        .we_cv     (we_cv),
        .flags     (flags),
        .cond_ok   (cond_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RESET_STATE;
        else        state <= next_state;
    end

    always_comb begin
        next_state    = state;
        pcw_c         = 1'b0;
        irw_c         = 1'b0;
        regw_c        = 1'b0;
        memw_c        = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_RD2;
        ALUControl    = ALU_ADD;
        illegal_instr = 1'b0;
        we_nz         = 1'b0;
        we_cv         = 1'b0;

        case (state)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                irw_c     = mem_ready;
                pcw_c     = mem_ready;
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                // An unsupported encoding is flagged even when its condition fails.
                if (op == OP_ILL || (op == OP_DP && !cmd_legal(cmd))) begin
                    illegal_instr = 1'b1;
                    next_state    = FETCH;
                end else if (!cond_ok) begin
                    next_state = FETCH;
                end else begin
                    case (op)
                        OP_DP:   next_state = funct[5] ? EXECUTEI : EXECUTER;
                        OP_MEM:  next_state = MEMADR;
                        OP_BR:   next_state = BRANCH;
                        default: next_state = FETCH;
                    endcase
                end
            end
            MEMADR: begin
                ALUSrcB    = SRCB_EXTIMM;
                next_state = funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                memw_c = 1'b1;
                if (mem_ready) next_state = FETCH;
            end
            MEMWB: begin
                ResultSrc  = RES_READDATA;
                regw_c     = 1'b1;
                pcw_c      = rd_pc;
                next_state = FETCH;
            end
            EXECUTER, EXECUTEI: begin
                ALUSrcB    = (state == EXECUTEI) ? SRCB_EXTIMM : SRCB_RD2;
                ALUControl = alu_decode(cmd);
                we_nz      = funct[0];
                we_cv      = funct[0] & cmd_arith(cmd);
                next_state = ALUWB;
            end
            ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                regw_c     = ~is_cmp;
                pcw_c      = rd_pc & ~is_cmp;
                next_state = FETCH;
            end
            BRANCH: begin
                ALUSrcB    = SRCB_EXTIMM;
                ResultSrc  = RES_ALURESULT;
                pcw_c      = 1'b1;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

    // Write enables must be inactive for as long as reset is asserted,
    // even though FETCH would otherwise follow mem_ready.
    assign PCWrite  = pcw_c  & rst_n;
    assign IRWrite  = irw_c  & rst_n;
    assign RegWrite = regw_c & rst_n;
    assign MemWrite = memw_c & rst_n;

`ifdef PERF_CNT_EN
    logic retire;

    assign retire = (next_state == FETCH) &&
                    ((state == MEMWB) || (state == MEMWRITE) ||
                     (state == ALUWB) || (state == BRANCH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= 32'd0;
            retired_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (retire) retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control unit for the multicycle ARM-subset datapath (ADD/SUB/AND/ORR/CMP/MOV, LDR/STR, B), which shares one memory port and one ALU across instruction phases. A Moore FSM sequences fetch, decode, execute, memory and writeback, with wait states driven by a memory ready handshake. It holds the NZCV flags register, evaluates the condition field once per instruction, and drives all datapath enables and muxes.

Parameters:
RESET_STATE, FETCH, state entered on reset (kept for bench override only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
instr  in  32  instruction register contents; fields Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
alu_flags  in  4  NZCV from ALU, current cycle
mem_ready  in  1  memory has completed the access this cycle
PCWrite  out  1  PC register enable
IRWrite  out  1  instruction register enable
RegWrite  out  1  register file write enable
MemWrite  out  1  data memory write strobe
AdrSrc  out  1  0=PC, 1=ALUOut to memory address
ResultSrc  out  2  00 ALUOut, 01 ReadData, 10 ALUResult
ALUSrcA  out  1  0=RD1, 1=PC
ALUSrcB  out  2  00 RD2, 01 ExtImm, 10 constant 4
ImmSrc  out  2  instr[27:26]
RegSrc  out  2  [0]=Op==10, [1]=Op==01 & ~Funct[0]
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
illegal_instr  out  1  one-cycle pulse on unsupported encoding

Behaviour:
- Reset (rst_n=0, asynchronous): state=FETCH, flags=0000, and PCWrite/IRWrite/RegWrite/MemWrite forced to 0 while reset is held. Mux outputs take their FETCH values.
- States and transitions:
  - FETCH -> DECODE when mem_ready, else stay in FETCH.
  - DECODE -> FETCH if cond fails; Op=00 & Funct[5] -> EXECUTEI; Op=00 -> EXECUTER; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> FETCH with illegal_instr=1.
  - MEMADR -> MEMREAD if Funct[0], else MEMWRITE.
  - MEMREAD -> MEMWB when mem_ready.
  - MEMWRITE -> FETCH when mem_ready.
  - EXECUTER/EXECUTEI -> ALUWB.
  - MEMWB, ALUWB and BRANCH -> FETCH.
- Per-state outputs (all Moore):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10; IRWrite=PCWrite=mem_ready.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8 to R15 read path).
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ADD.
  - MEMREAD: AdrSrc=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1 held until mem_ready.
  - MEMWB: ResultSrc=01, RegWrite=1; PCWrite=1 if Rd=15.
  - EXECUTER/EXECUTEI: ALUSrcA=0, ALUSrcB=00 or 01.
  - ALUWB: ResultSrc=00; RegWrite=1 unless CMP (Funct[4:1]=1010); PCWrite=1 if Rd=15 and not CMP.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=1.
- ALU decode in EXECUTE states: Funct[4:1] 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 SUB, 1101 ORR. Any other value -> illegal_instr pulse in DECODE and return to FETCH.
- Flags update at the end of the EXECUTE cycle when Funct[0]=1: NZ always; CV only for ADD/SUB.
- Conditions: EQ..LE standard ARM, 1110 AL, 1111 never. Evaluated only in DECODE against the registered flags.
- Unused outputs are 0 in every state; no latches.
- Reset mid-instruction abandons it; flags are cleared.

Optional Feature:
PERF_CNT_EN: adds outputs cycle_cnt[31:0] (increments every non-reset cycle) and retired_cnt[31:0] (increments on entry to FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH). Both counters reset to 0 and wrap at 2^32. Without the macro, neither port nor the counters exist.

Decomposition:
- ctrl_pkg: state_t enum, cond_t codes, ALUControl and ResultSrc/ALUSrcB encodings, CMP/MOV Funct constants.
- Sub-module cond_unit: flags register plus condition check, producing cond_ok.

Test Plan:
- Reset held, then released with mem_ready=1 and instr=ADD R1,R2,R3 (E0821003) -> IRWrite and PCWrite high in cycle 0, ALUWB at cycle 3 with RegWrite=1 and ALUControl=00.
- LDR (E5921004) with mem_ready low 2 cycles in MEMREAD -> stays in MEMREAD for 2 extra cycles, then MEMWB with ResultSrc=01 and RegWrite=1.
- CMPS giving Z (alu_flags=0100), then BEQ -> BRANCH with PCWrite=1; BNE instead -> FETCH right after DECODE, no writes.
- STR (E5821000) -> MemWrite=1 only in MEMWRITE, held until mem_ready, RegWrite=0 throughout.
- instr with Op=11, or Funct[4:1]=0111 -> illegal_instr pulses for one cycle in DECODE and the next state is FETCH.
- rst_n dropped in MEMWRITE -> MemWrite is 0 immediately, and on release the FSM is in FETCH with flags=0000.
